// File: rtl/fe.sv
// fe: RV32 instruction fetch stage with single-outstanding imem handshake and 1-entry skid buffer
module fe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pcn,
  output logic                  valid
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  state_t state;
  logic [ADDR_WIDTH-1:0] pc_f, pc_q, skid_pc;
  logic [DATA_WIDTH-1:0] instr_q, skid_instr;
  logic kill, stale;
  assign imem_req = state == S_REQ;
  assign imem_addr = pc_f;
  assign instr = valid ? instr_q : NOP_INSTR;
  // a redirect leaves a request in flight when it lands on a grant or an unanswered wait
  assign stale = (state == S_REQ && imem_gnt) || (state == S_WAIT && !imem_rvalid);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc_f <= RESET_PC;
      pc_q <= RESET_PC;
      kill <= 1'b0;
      valid <= 1'b0;
      instr_q <= NOP_INSTR;
      pc <= RESET_PC;
      pcn <= RESET_PC + FOUR;
      skid_instr <= NOP_INSTR;
      skid_pc <= RESET_PC;
    end else if (redirect) begin
      pc_f <= redirect_pc & ~ADDR_WIDTH'(3);
      valid <= 1'b0;
      state <= stale ? S_WAIT : S_REQ;
      kill <= stale;
    end else begin
      if (valid && en) valid <= 1'b0;
      case (state)
        S_REQ: if (imem_gnt) begin
          pc_q <= pc_f;
          pc_f <= pc_f + FOUR;
          state <= S_WAIT;
        end
        S_WAIT: if (imem_rvalid) begin
          if (kill) begin
            kill <= 1'b0;
            state <= S_REQ;
          end else if (!valid || en) begin
            instr_q <= imem_rdata;
            pc <= pc_q;
            pcn <= pc_q + FOUR;
            valid <= 1'b1;
            state <= S_REQ;
          end else begin
            skid_instr <= imem_rdata;
            skid_pc <= pc_q;
            state <= S_FULL;
          end
        end
        S_FULL: if (en) begin
          instr_q <= skid_instr;
          pc <= skid_pc;
          pcn <= skid_pc + FOUR;
          valid <= 1'b1;
          state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_fe.sv
// tb_fe: scoreboard bench for fe with a behavioural instruction memory
module tb_fe;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcn;
  } slot_t;
  logic clk = 0, rst, en, redirect, imem_req, imem_gnt, imem_rvalid, valid, gnt_en;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, pc, pcn;
  slot_t q[$];
  int errs = 0, checks = 0, lat = 1, cyc = 0, due = 0;
  logic pending = 0, tainted = 0;
  logic [31:0] paddr = 0;

  fe dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .pcn(pcn), .valid(valid)
  );

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en && imem_req;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 0 ? 32'h11 : a == 4 ? 32'h22 : a == 8 ? 32'h33 : a ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory drives responses just after the edge, lat cycles after the grant
  always @(posedge clk) begin
    cyc = cyc + 1;
    imem_rvalid <= !rst && pending && cyc == due;
    imem_rdata <= word(paddr);
  end

  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      q.delete();
    end else begin
      if (!valid) chk("nop", instr, 32'h13);
      if (valid && en) begin
        if (q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
        else begin
          slot_t e;
          e = q.pop_front();
          chk("sb_instr", instr, e.instr);
          chk("sb_pc", pc, e.pc);
          chk("sb_pcn", pcn, e.pcn);
        end
      end
      if (redirect) q.delete();
      if (imem_req && imem_gnt) begin
        pending = 1;
        paddr = imem_addr;
        due = cyc + lat;
        tainted = redirect;
      end else if (pending) begin
        if (imem_rvalid) begin
          if (!(tainted || redirect)) q.push_back('{word(paddr), paddr, paddr + 32'd4});
          pending = 0;
        end else if (redirect) tainted = 1;
      end
    end
  end

  task automatic release_rst();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_pc", pc, 0);
    chk("rst_pcn", pcn, 4);
    chk("rst_req", 32'(imem_req), 1);
    chk("rst_addr", imem_addr, 0);
  endtask

  task automatic wait_valid_pc(input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid && pc == a) && n < 60);
    chk("wait_pc", 32'(valid && pc == a), 1);
  endtask

  task automatic wait_req_addr(input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr == a) && n < 60);
    chk("wait_req", 32'(imem_req && imem_addr == a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    int n;
    rst = 1; en = 1; redirect = 0; redirect_pc = 0; gnt_en = 1;
    #3 chk_reset_outputs();
    release_rst();
    pat = 7'b1010100;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("line_valid", 32'(valid), 32'(pat[k]));
    end
    // stall into skid
    rst = 1;
    release_rst();
    repeat (4) @(posedge clk);
    #1 en = 0;
    @(negedge clk);
    chk("stall_pc4", pc, 4);
    chk("stall_v", 32'(valid), 1);
    @(negedge clk);
    @(negedge clk);
    chk("full_req", 32'(imem_req), 0);
    chk("full_pc", pc, 4);
    @(posedge clk);
    #1 en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("skid_pc", pc, 8);
    chk("skid_instr", instr, 32'h33);
    chk("after_req", 32'(imem_req), 1);
    chk("after_addr", imem_addr, 12);
    // redirect while outstanding
    #1 lat = 2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 20);
    @(posedge clk);
    #1 redirect = 1; redirect_pc = 32'h100;
    @(posedge clk);
    #1 redirect = 0;
    @(negedge clk);
    chk("drop_valid", 32'(valid), 0);
    @(negedge clk);
    chk("rd_req", 32'(imem_req), 1);
    chk("rd_addr", imem_addr, 32'h100);
    wait_valid_pc(32'h100);
    // redirect on the grant cycle
    @(posedge clk);
    #1 gnt_en = 0; redirect = 1; redirect_pc = 32'h20;
    @(posedge clk);
    #1 redirect = 0; lat = 1;
    wait_req_addr(32'h20);
    @(posedge clk);
    #1 gnt_en = 1; redirect = 1; redirect_pc = 32'h203;
    @(posedge clk);
    #1 redirect = 0;
    @(negedge clk);
    chk("kill_wait", 32'(imem_req), 0);
    @(negedge clk);
    chk("kill_req", 32'(imem_req), 1);
    chk("kill_addr", imem_addr, 32'h200);
    wait_valid_pc(32'h200);
    // wrap with 3-cycle latency
    #1 lat = 3;
    @(posedge clk);
    #1 redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 redirect = 0;
    wait_valid_pc(32'hFFFF_FFFC);
    chk("wrap_pcn", pcn, 0);
    chk("wrap_addr", imem_addr, 0);
    // async reset in WAIT with valid held
    #1 en = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    @(negedge clk);
    chk("pre_wait_req", 32'(imem_req), 0);
    chk("pre_wait_v", 32'(valid), 1);
    #2 rst = 1;
    #1 chk_reset_outputs();
    lat = 1;
    release_rst();
    // async reset in FULL
    repeat (5) @(negedge clk);
    chk("pre_full_req", 32'(imem_req), 0);
    chk("pre_full_v", 32'(valid), 1);
    chk("pre_full_pc", pc, 0);
    #2 rst = 1;
    #1 chk_reset_outputs();
    release_rst();
    @(negedge clk);
    chk("restart_req", 32'(imem_req), 1);
    chk("restart_addr", imem_addr, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fe.md
Name: fe

Overview:
Instruction fetch stage of the 5-stage RV32 pipeline, directly upstream of the decode stage. It owns the fetch PC and issues word requests over a request/grant/response instruction-memory handshake, with one request outstanding at a time. It presents {instr, pc, pcn, valid} to decode and accepts redirects (taken branch / jal / jalr) from execute. A 1-entry skid buffer absorbs a response that arrives while decode is stalled.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven while invalid (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  decode accepts the current output this cycle (stall when 0)
redirect  in  1  execute requests a PC change
redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 0
imem_req  out  1  request valid
imem_addr  out  ADDR_WIDTH  word address of request (pc_f)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid; at least 1 cycle after grant
imem_rdata  in  DATA_WIDTH  response instruction
instr  out  DATA_WIDTH  instruction to decode
pc  out  ADDR_WIDTH  address of instr
pcn  out  ADDR_WIDTH  pc+4
valid  out  1  output slot holds a real instruction

Behaviour:
- Reset (async, rst=1): state=REQ, pc_f=RESET_PC, kill=0, valid=0, skid empty, instr=NOP_INSTR, pc=RESET_PC, pcn=RESET_PC+4. First request is issued in the first cycle after rst deasserts.
- All adds are modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC+4 wraps to 0.
- Handoff: a slot transfers to decode when valid && en. When valid=0, instr=NOP_INSTR.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc_f. On gnt: pc_q<=pc_f, pc_f<=pc_f+4, next state WAIT.
  - WAIT: imem_req=0. On rvalid with kill=1: discard the data, kill<=0, next state REQ.
    On rvalid with kill=0 and (!valid || en): the output register loads {imem_rdata, pc_q, pc_q+4, valid=1}, next state REQ.
    On rvalid with kill=0 and valid && !en: the skid buffer loads the same data, next state FULL.
  - FULL: imem_req=0. When en=1: the output register loads from the skid, skid is emptied, next state REQ.
- Consumption without refill: if valid && en and no new data arrives, valid<=0 next cycle.
- Throughput: at most 1 instruction per 2 cycles (grant cycle plus at least 1 response cycle). No combinational path from imem_rvalid to imem_req.
- Redirect has the highest priority over every other event in the same cycle:
  - pc_f<={redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - valid<=0 and the skid buffer is emptied.
  - In REQ without gnt: next state REQ.
  - In REQ with gnt the same cycle: the granted request is stale. Next state WAIT, kill<=1, pc_f is not incremented.
  - In WAIT without rvalid: kill<=1, stay in WAIT.
  - In WAIT with rvalid the same cycle: drop the data, kill<=0, next state REQ.
  - In FULL: next state REQ.
- imem_addr is stable and imem_req stays high while in REQ until gnt.
- Reset mid-transaction: the outstanding request is abandoned. The memory must not return a response for a request granted before reset.

Test Plan:
- Reset then straight-line: gnt in every REQ cycle, rvalid 1 cycle after gnt, en=1, instr words 0x11,0x22,0x33 -> valid pulses carrying pc=0,4,8 and pcn=4,8,12, one instruction every 2 cycles; instr=0x13 while valid=0.
- Stall with skid: en=0 while valid with pc=4, next response 0x33 arrives -> state FULL, imem_req=0. Raise en -> output becomes pc=8/0x33 the next cycle, then the fetch of 12 is issued.
- Redirect while outstanding: redirect=1, redirect_pc=0x100 in WAIT, response arrives 2 cycles later -> response dropped, valid stays 0, next imem_addr=0x100, next valid instruction has pc=0x100.
- Redirect coincident with gnt in REQ at pc_f=0x20, redirect_pc=0x203 -> its response is killed, following request address=0x200 (not 0x24).
- Wrap and latency: redirect_pc=0xFFFF_FFFC, rvalid 3 cycles after gnt -> pc=0xFFFF_FFFC, pcn=0, next imem_addr=0.
- Async reset asserted in WAIT and FULL with valid=1 -> all outputs return to their reset values immediately, without waiting for a clock edge.
